mult_share_sched: RTL and testbench

- Round-robin scheduler that shares one 4x4 Wallace-tree multiplier datapath between NREQ requesters.
- Each requester presents operand pairs with a valid/ready handshake.
- The scheduler grants one request, registers its operands, drives the shared multiplier, registers the 8-bit product and returns it with the requester ID on a valid/ready response channel.
- Sits between requesting engines and the single combinational multiplier instance.

---
 rtl/mult_share_pkg.sv | 17 +
 rtl/mult_share_sched_if.sv | 29 ++
 rtl/rr_arbiter.sv | 36 +++
 rtl/wallace_tree_multiplier.sv | 24 ++
 rtl/mult_share_sched.sv | 129 ++++++++++++
 tb/tb_mult_share_sched.sv | 183 ++++++++++++++++++
 6 files changed

// File: rtl/mult_share_pkg.sv
// Shared constants, scheduler state type and saturating counter helper for mult_share_sched.
package mult_share_pkg;

  localparam int unsigned OP_W   = 4;
  localparam int unsigned PROD_W = 8;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    RESP
  } sched_state_t;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == '1) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/mult_share_sched_if.sv
// Request/response bundle between requesting engines (master) and mult_share_sched (slave).
interface mult_share_sched_if
  import mult_share_pkg::*;
#(
  parameter int unsigned NREQ = 4,
  parameter int unsigned ID_W = $clog2(NREQ)
);

  logic [NREQ-1:0]      req_valid;
  logic [NREQ*OP_W-1:0] req_a;
  logic [NREQ*OP_W-1:0] req_b;
  logic [NREQ-1:0]      req_ready;
  logic                 resp_valid;
  logic                 resp_ready;
  logic [PROD_W-1:0]    resp_p;
  logic [ID_W-1:0]      resp_id;
  logic                 busy;

  modport slave (
    input  req_valid, req_a, req_b, resp_ready,
    output req_ready, resp_valid, resp_p, resp_id, busy
  );

  modport master (
    output req_valid, req_a, req_b, resp_ready,
    input  req_ready, resp_valid, resp_p, resp_id, busy
  );

endinterface

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: first set request at or above i_ptr, wrapping, as one-hot and index.
module rr_arbiter #(
  parameter int unsigned NREQ = 4,
  parameter int unsigned ID_W = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] i_req,
  input  logic [ID_W-1:0] i_ptr,
  output logic [NREQ-1:0] o_grant,
  output logic [ID_W-1:0] o_idx,
  output logic            o_any
);

  int unsigned     w_k;
  logic [ID_W-1:0] w_kk;

  // Walk from the farthest offset down so the closest requester to i_ptr wins last.
  always_comb begin
    o_grant = '0;
    o_idx   = '0;
    o_any   = 1'b0;
    w_k     = 0;
    w_kk    = '0;
    for (int unsigned off = NREQ; off > 0; off--) begin
      w_k = 32'(i_ptr) + off - 1;
      if (w_k >= NREQ) w_k = w_k - NREQ;
      w_kk = ID_W'(w_k);
      if (i_req[w_kk]) begin
        o_grant       = '0;
        o_grant[w_kk] = 1'b1;
        o_idx         = w_kk;
        o_any         = 1'b1;
      end
    end
  end

endmodule

// File: rtl/wallace_tree_multiplier.sv
// Unsigned 4x4 Wallace-tree multiplier: two 3:2 carry-save stages then a final carry-propagate add.
module wallace_tree_multiplier
  import mult_share_pkg::*;
(
  input  logic [OP_W-1:0]   i_a,
  input  logic [OP_W-1:0]   i_b,
  output logic [PROD_W-1:0] o_p
);

  logic [PROD_W-1:0] w_pp [OP_W];
  logic [PROD_W-1:0] w_s1, w_c1, w_s2, w_c2;

  for (genvar gi = 0; gi < OP_W; gi++) begin : g_pp
    assign w_pp[gi] = i_b[gi] ? (PROD_W'(i_a) << gi) : '0;
  end

  // Carries out of bit 7 are dropped; the product never exceeds 8 bits so the sum stays exact.
  assign w_s1 = w_pp[0] ^ w_pp[1] ^ w_pp[2];
  assign w_c1 = ((w_pp[0] & w_pp[1]) | (w_pp[0] & w_pp[2]) | (w_pp[1] & w_pp[2])) << 1;
  assign w_s2 = w_s1 ^ w_c1 ^ w_pp[3];
  assign w_c2 = ((w_s1 & w_c1) | (w_s1 & w_pp[3]) | (w_c1 & w_pp[3])) << 1;
  assign o_p  = w_s2 + w_c2;

endmodule

// File: rtl/mult_share_sched.sv
// Round-robin scheduler sharing one 4x4 multiplier among NREQ requesters.
// Optional MULT_SHARE_STATS_EN adds op_count / stall_cycles saturating counters.
module mult_share_sched
  import mult_share_pkg::*;
#(
  parameter int unsigned NREQ = 4,
  parameter int unsigned ID_W = $clog2(NREQ)
) (
  input  logic                 clk,
  input  logic                 rst,
  mult_share_sched_if.slave    bus
`ifdef MULT_SHARE_STATS_EN
  ,
  output logic [15:0]          op_count,
  output logic [15:0]          stall_cycles
`endif
);

  sched_state_t      r_state;
  logic [ID_W-1:0]   r_rr_ptr;
  logic [ID_W-1:0]   r_gnt_id;
  logic [OP_W-1:0]   r_op_a;
  logic [OP_W-1:0]   r_op_b;
  logic [PROD_W-1:0] r_resp_p;
  logic [ID_W-1:0]   r_resp_id;
  logic              r_resp_valid;
  logic              r_busy;

  logic [NREQ-1:0]   w_grant;
  logic [ID_W-1:0]   w_idx;
  logic              w_any;
  logic              w_accept;
  logic [OP_W-1:0]   w_sel_a;
  logic [OP_W-1:0]   w_sel_b;
  logic [PROD_W-1:0] w_prod;
  logic [ID_W-1:0]   w_ptr_next;

  rr_arbiter #(
    .NREQ (NREQ),
    .ID_W (ID_W)
  ) u_arb (
    .i_req   (bus.req_valid),
    .i_ptr   (r_rr_ptr),
    .o_grant (w_grant),
    .o_idx   (w_idx),
    .o_any   (w_any)
  );

  wallace_tree_multiplier u_mult (
    .i_a (r_op_a),
    .i_b (r_op_b),
    .o_p (w_prod)
  );

  // Reset overrides any same-cycle accept so nothing is handed over during reset.
  assign w_accept      = (r_state == IDLE) && !rst && w_any;
  assign bus.req_ready = w_accept ? w_grant : '0;

  assign w_sel_a    = bus.req_a[w_idx*OP_W +: OP_W];
  assign w_sel_b    = bus.req_b[w_idx*OP_W +: OP_W];
  assign w_ptr_next = (r_resp_id == ID_W'(NREQ - 1)) ? '0 : r_resp_id + 1'b1;

  assign bus.resp_valid = r_resp_valid;
  assign bus.resp_p     = r_resp_p;
  assign bus.resp_id    = r_resp_id;
  assign bus.busy       = r_busy;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= IDLE;
      r_rr_ptr     <= '0;
      r_gnt_id     <= '0;
      r_op_a       <= '0;
      r_op_b       <= '0;
      r_resp_p     <= '0;
      r_resp_id    <= '0;
      r_resp_valid <= 1'b0;
      r_busy       <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_any) begin
            r_op_a   <= w_sel_a;
            r_op_b   <= w_sel_b;
            r_gnt_id <= w_idx;
            r_busy   <= 1'b1;
            r_state  <= CALC;
          end
        end
        CALC: begin
          r_resp_p     <= w_prod;
          r_resp_id    <= r_gnt_id;
          r_resp_valid <= 1'b1;
          r_state      <= RESP;
        end
        RESP: begin
          if (bus.resp_ready) begin
            r_rr_ptr     <= w_ptr_next;
            r_resp_valid <= 1'b0;
            r_busy       <= 1'b0;
            r_state      <= IDLE;
          end
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

`ifdef MULT_SHARE_STATS_EN
  logic [15:0] r_op_count;
  logic [15:0] r_stall_cycles;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_op_count     <= '0;
      r_stall_cycles <= '0;
    end else if (r_state == RESP) begin
      if (bus.resp_ready) r_op_count     <= sat_inc16(r_op_count);
      else                r_stall_cycles <= sat_inc16(r_stall_cycles);
    end
  end

  assign op_count     = r_op_count;
  assign stall_cycles = r_stall_cycles;
`endif

endmodule

// File: tb/tb_mult_share_sched.sv
// Directed + randomized bench for mult_share_sched with a transaction-level reference model.
module tb_mult_share_sched;

  localparam int NREQ = 4;

  logic clk = 1'b0;
  logic rst;

  mult_share_sched_if #(.NREQ(NREQ)) bus ();

`ifdef MULT_SHARE_STATS_EN
  logic [15:0] op_count;
  logic [15:0] stall_cycles;
`endif

  mult_share_sched #(.NREQ(NREQ)) dut (
    .clk          (clk),
    .rst          (rst),
    .bus          (bus)
`ifdef MULT_SHARE_STATS_EN
    ,
    .op_count     (op_count),
    .stall_cycles (stall_cycles)
`endif
  );

  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;
  int mptr   = 0;
  int m_ops  = 0;
  int m_stall = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Lowest-priority-last rule: first valid requester at or after mptr, circularly.
  function automatic int model_grant(input logic [3:0] m);
    for (int off = 0; off < NREQ; off++)
      if (m[(mptr + off) % NREQ]) return (mptr + off) % NREQ;
    return -1;
  endfunction

  task automatic txn(input logic [3:0] mask, input logic [15:0] av, input logic [15:0] bv,
                     input int stall);
    int g;
    int exp_p;
    bus.req_valid  = mask;
    bus.req_a      = av;
    bus.req_b      = bv;
    bus.resp_ready = 1'($urandom_range(0, 1));
    #1;
    g     = model_grant(mask);
    exp_p = int'((av >> (4 * g)) & 16'hF) * int'((bv >> (4 * g)) & 16'hF);
    chk("accept_ready", 32'(bus.req_ready), 32'(1 << g));
    chk("accept_busy", 32'(bus.busy), 0);
    tick();
    bus.req_valid  = 4'($urandom);
    bus.req_a      = 16'($urandom);
    bus.req_b      = 16'($urandom);
    bus.resp_ready = 1'($urandom_range(0, 1));
    #1;
    chk("calc_busy", 32'(bus.busy), 1);
    chk("calc_valid", 32'(bus.resp_valid), 0);
    chk("calc_ready", 32'(bus.req_ready), 0);
    tick();
    for (int s = 0; s <= stall; s++) begin
      bus.resp_ready = (s == stall);
      bus.req_valid  = 4'($urandom);
      #1;
      chk("resp_valid", 32'(bus.resp_valid), 1);
      chk("resp_p", 32'(bus.resp_p), 32'(exp_p));
      chk("resp_id", 32'(bus.resp_id), 32'(g));
      chk("resp_ready_blk", 32'(bus.req_ready), 0);
      tick();
      if (s < stall) m_stall++;
    end
    m_ops++;
    mptr = (g + 1) % NREQ;
    bus.req_valid  = '0;
    bus.resp_ready = 1'($urandom_range(0, 1));
    #1;
    chk("post_valid", 32'(bus.resp_valid), 0);
    chk("post_busy", 32'(bus.busy), 0);
`ifdef MULT_SHARE_STATS_EN
    chk("op_count", 32'(op_count), 32'(m_ops));
    chk("stall_cycles", 32'(stall_cycles), 32'(m_stall));
`endif
  endtask

  initial begin
    logic [15:0] av;
    logic [15:0] bv;
    logic [3:0]  mask;
    int          g;
    int          stall;

    // Reset with requests pending: reset must suppress any accept.
    rst = 1'b1;
    bus.req_valid  = 4'hF;
    bus.req_a      = 16'h1234;
    bus.req_b      = 16'h5678;
    bus.resp_ready = 1'b1;
    tick();
    tick();
    chk("rst_req_ready", 32'(bus.req_ready), 0);
    chk("rst_resp_valid", 32'(bus.resp_valid), 0);
    chk("rst_busy", 32'(bus.busy), 0);
    chk("rst_resp_p", 32'(bus.resp_p), 0);
    chk("rst_resp_id", 32'(bus.resp_id), 0);
    rst = 1'b0;
    bus.req_valid = '0;
    tick();
    chk("idle_no_req", 32'(bus.req_ready), 0);
    chk("idle_no_valid", 32'(bus.resp_valid), 0);

    // Single request from requester 0: 3*5.
    txn(4'b0001, 16'h0003, 16'h0005, 0);

    // All requesters continuously, a=i+1, b=15.
    for (int t = 0; t < 5; t++) txn(4'b1111, 16'h4321, 16'hFFFF, 0);

    // Max operands from requester 2.
    txn(4'b0100, 16'h0F00, 16'h0F00, 0);

    // Backpressure for five RESP cycles.
    txn(4'b0010, 16'h00D0, 16'h00B0, 5);

    // Reset while in CALC discards the transaction.
    bus.req_valid = 4'hF;
    bus.req_a     = 16'hFFFF;
    bus.req_b     = 16'hFFFF;
    #1;
    chk("pre_rst_accept", 32'(bus.req_ready), 32'(1 << model_grant(4'hF)));
    tick();
    rst = 1'b1;
    tick();
    #1;
    chk("rst_wins_ready", 32'(bus.req_ready), 0);
    rst = 1'b0;
    bus.req_valid = '0;
    mptr = 0;
    m_ops = 0;
    m_stall = 0;
    #1;
    chk("abort_valid", 32'(bus.resp_valid), 0);
    chk("abort_busy", 32'(bus.busy), 0);
    chk("abort_resp_p", 32'(bus.resp_p), 0);
    for (int t = 0; t < 3; t++) begin
      tick();
      chk("abort_no_resp", 32'(bus.resp_valid), 0);
    end
    txn(4'b1010, 16'h7000, 16'h0090, 0);
    txn(4'b1000, 16'h9000, 16'h7000, 0);

    // Every operand pair, routed to whichever requester the model expects to win.
    for (int p = 0; p < 256; p++) begin
      mask = 4'($urandom_range(1, 15));
      g    = model_grant(mask);
      av   = 16'($urandom);
      bv   = 16'($urandom);
      av[4*g +: 4] = 4'(p);
      bv[4*g +: 4] = 4'(p >> 4);
      stall = ($urandom_range(0, 7) == 0) ? $urandom_range(1, 3) : 0;
      txn(mask, av, bv, stall);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
